// File: rtl/ws281x_encoder.sv
`timescale 1ns/1ps
// ws281x_encoder: serialises 24-bit node values MSB first into WS281X NRZ bit periods, with latch gaps on request.
module ws281x_encoder #(
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int TBIT_CYC  = 63,
  parameter int LATCH_CYC = 2600
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [23:0] Node,
  input  logic        Valid,
  output logic        Ready,
  input  logic        Flush,
  output logic        Dout,
  output logic        Busy,
  output logic        Done
);
  localparam int CW = $clog2(LATCH_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2;
  localparam logic [CW-1:0] T0 = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1 = CW'(T1H_CYC);
  localparam logic [CW-1:0] BMAX = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] LMAX = CW'(LATCH_CYC - 1);
  logic [1:0] state;
  logic [CW-1:0] cyc;
  logic [4:0] bit_idx;
  logic [23:0] shreg;
  logic armed;
  logic bit_end, last, accept, go_latch;
  assign bit_end = state == SEND && cyc == BMAX;
  assign last = bit_end && bit_idx == 5'd0;
  assign Ready = state == IDLE || last;
  assign accept = Valid && Ready;
  // a held Flush issues one latch; it must drop or a new node must be accepted to re-arm
  assign go_latch = Flush && armed && !accept && (state == IDLE || last);
  assign Busy = state != IDLE;
  assign Done = state == LATCH && cyc == LMAX;
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cyc <= '0;
      bit_idx <= '0;
      shreg <= '0;
      Dout <= 1'b0;
      armed <= 1'b1;
    end else begin
      Dout <= state == SEND && cyc < (shreg[23] ? T1 : T0);
      armed <= go_latch ? 1'b0 : (accept || !Flush) ? 1'b1 : armed;
      if (accept) begin
        state <= SEND;
        cyc <= '0;
        bit_idx <= 5'd23;
        shreg <= Node;
      end else if (go_latch) begin
        state <= LATCH;
        cyc <= '0;
      end else if (state == SEND) begin
        if (!bit_end) cyc <= cyc + 1'b1;
        else if (bit_idx != 5'd0) begin
          cyc <= '0;
          bit_idx <= bit_idx - 1'b1;
          shreg <= {shreg[22:0], 1'b0};
        end else begin
          state <= IDLE;
          cyc <= '0;
        end
      end else if (state == LATCH) begin
        state <= cyc == LMAX ? IDLE : LATCH;
        cyc <= cyc == LMAX ? '0 : cyc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ws281x_encoder.sv
`timescale 1ns/1ps
// tb_ws281x_encoder: directed checks of bit timing, back-to-back nodes, latch gaps and async reset.
module tb_ws281x_encoder;
  logic Clock = 0, nReset, Valid, Flush, Ready, Dout, Busy, Done;
  logic [23:0] Node, got;
  int vecs = 0, errs = 0, cnt;
  ws281x_encoder dut (.Clock(Clock), .nReset(nReset), .Node(Node), .Valid(Valid), .Ready(Ready),
                      .Flush(Flush), .Dout(Dout), .Busy(Busy), .Done(Done));
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic start(input logic [23:0] v);
    Node = v;
    Valid = 1;
    step();
    Valid = 0;
    chk("start_busy", {31'd0, Busy}, 1);
    chk("start_ready", {31'd0, Ready}, 0);
  endtask
  // decodes one node from Dout; each bit window must be a high prefix of 20 or 40 cycles
  task automatic recv(input logic chain, input logic [23:0] nxt, input logic scramble, output logic [23:0] v);
    int hi, bad, rcnt, ridx, i;
    logic shape;
    v = '0; bad = 0; rcnt = 0; ridx = -1;
    for (int b = 0; b < 24; b++) begin
      hi = 0; shape = 1;
      for (int c = 0; c < 63; c++) begin
        step();
        i = b * 63 + c;
        if (Dout) begin
          if (hi != c) shape = 0;
          hi++;
        end
        if (Ready && i <= 1510) begin
          rcnt++;
          ridx = i;
        end
        if (scramble) Node = 24'($urandom);
        if (chain && i == 1510) begin
          Node = nxt;
          Valid = 1;
        end
        if (chain && i == 1511) Valid = 0;
      end
      if (!shape || (hi != 20 && hi != 40)) bad++;
      v = {v[22:0], hi == 40};
    end
    chk("bit_shape", bad, 0);
    chk("ready_count", rcnt, 1);
    chk("ready_cycle", ridx, 1510);
  endtask
  task automatic latch_chk();
    int bad, dcnt, didx;
    bad = 0; dcnt = 0; didx = -1;
    for (int j = 0; j < 2600; j++) begin
      if (Dout || !Busy) bad++;
      if (Done) begin
        dcnt++;
        didx = j;
      end
      step();
    end
    chk("latch_low", bad, 0);
    chk("done_count", dcnt, 1);
    chk("done_cycle", didx, 2599);
    chk("latch_end_busy", {31'd0, Busy}, 0);
    chk("latch_end_done", {31'd0, Done}, 0);
    chk("latch_end_ready", {31'd0, Ready}, 1);
  endtask
  initial begin
    nReset = 0; Valid = 0; Flush = 0; Node = '0;
    repeat (3) step();
    chk("rst_dout", {31'd0, Dout}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_ready", {31'd0, Ready}, 1);
    nReset = 1;
    step();
    start(24'hFF0000);
    recv(0, 24'h0, 0, got);
    chk("node_ff0000", {8'd0, got}, 32'hFF0000);
    chk("idle_busy", {31'd0, Busy}, 0);
    chk("idle_ready", {31'd0, Ready}, 1);
    start(24'hAAAAAA);
    recv(1, 24'h555555, 0, got);
    chk("node_aaaaaa", {8'd0, got}, 32'hAAAAAA);
    recv(0, 24'h0, 0, got);
    chk("node_555555", {8'd0, got}, 32'h555555);
    chk("b2b_idle", {31'd0, Busy}, 0);
    start(24'h0F0F0F);
    Flush = 1;
    recv(0, 24'h0, 0, got);
    chk("node_0f0f0f", {8'd0, got}, 32'h0F0F0F);
    chk("latch_busy", {31'd0, Busy}, 1);
    latch_chk();
    cnt = 0;
    repeat (10) begin
      step();
      if (Busy) cnt++;
    end
    chk("held_flush_single", cnt, 0);
    Flush = 0;
    step();
    Node = 24'hC3A55A; Valid = 1; Flush = 1;
    step();
    Valid = 0;
    chk("vf_busy", {31'd0, Busy}, 1);
    recv(0, 24'h0, 0, got);
    chk("node_c3a55a", {8'd0, got}, 32'hC3A55A);
    latch_chk();
    Flush = 0;
    step();
    start(24'h010203);
    recv(0, 24'h0, 1, got);
    chk("esc_scrambled", {8'd0, got}, 32'h010203);
    start(24'hFFFFFF);
    repeat (11 * 63 + 6) step();
    chk("bit12_high", {31'd0, Dout}, 1);
    nReset = 0;
    #1;
    chk("arst_dout", {31'd0, Dout}, 0);
    chk("arst_busy", {31'd0, Busy}, 0);
    chk("arst_done", {31'd0, Done}, 0);
    chk("arst_ready", {31'd0, Ready}, 1);
    step();
    nReset = 1;
    step();
    chk("post_rst_ready", {31'd0, Ready}, 1);
    start(24'h123456);
    recv(0, 24'h0, 0, got);
    chk("node_123456", {8'd0, got}, 32'h123456);
    chk("final_idle", {31'd0, Busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
